// File: rtl/input_conditioner_pkg.sv
// Shared clock constants: board clock, debounce defaults and the 1 Hz / 2 Hz divider terminal counts.
package input_conditioner_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // 10 ms of contact settle time at CLK_HZ
  localparam int unsigned DB_CYCLES_CLK = CLK_HZ / 100;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = DB_CYCLES_CLK;
  localparam int CNT_W_DEF       = 20;

  localparam int unsigned DIV_1HZ_MAX = CLK_HZ - 1;
  localparam int unsigned DIV_2HZ_MAX = CLK_HZ / 2 - 1;

  typedef struct packed {
    logic synced;
    logic stable;
  } chan_st_t;

endpackage

// File: rtl/input_conditioner_debounce_chan.sv
// One input channel: synchroniser chain, debounce counter, stable level and a registered 0->1 commit pulse.
module debounce_chan
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     raw_i,
  input  logic     arm_i,
  output chan_st_t st_o,
  output logic     rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Counter only runs while the synced level disagrees with stable, so it tops out at CNT_LAST
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
        rise_d   = synced & arm_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign st_o.synced = synced;
  assign st_o.stable = stable_q;
  assign rise_o      = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the ADJ/SEL slide switches and the PAUSE button; PAUSE yields one pulse per accepted press.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_adj_raw,
  input  logic sw_sel_raw,
  input  logic btn_pause_raw,
  output logic adj,
  output logic sel,
  output logic pause_tog
);

  chan_st_t adj_st, sel_st, pause_st;
  logic     adj_rise, sel_rise, pause_rise;

  logic [SYNC_STAGES-1:0] prime_q;
  logic                   armed_q, armed_d;
  logic                   unused_chan;

  debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_adj (
    .clk(clk), .rst(rst), .raw_i(sw_adj_raw), .arm_i(1'b0), .st_o(adj_st), .rise_o(adj_rise)
  );

  debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_sel (
    .clk(clk), .rst(rst), .raw_i(sw_sel_raw), .arm_i(1'b0), .st_o(sel_st), .rise_o(sel_rise)
  );

  debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_pause (
    .clk(clk), .rst(rst), .raw_i(btn_pause_raw), .arm_i(armed_q), .st_o(pause_st), .rise_o(pause_rise)
  );

  // Arming waits until the synchroniser holds a real post-reset sample, so a button held
  // through reset release is seen as pressed rather than as an idle zero from reset.
  assign armed_d = armed_q | (prime_q[SYNC_STAGES-1] & ~pause_st.synced & ~pause_st.stable);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_q <= '0;
      armed_q <= 1'b0;
    end else begin
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      armed_q <= armed_d;
    end
  end

  assign unused_chan = ^{adj_rise, sel_rise, adj_st.synced, sel_st.synced};

  assign adj       = adj_st.stable;
  assign sel       = sel_st.stable;
  assign pause_tog = pause_rise;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops per raw input (legal range 2..4).
REQ-002 Parameter DB_CYCLES, default 500000, number of consecutive clk cycles a synchronised input must hold a new level before it is accepted (legal minimum 2).
REQ-003 Parameter CNT_W, default 20, debounce counter width; SHALL satisfy 2^CNT_W > DB_CYCLES.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 sw_adj_raw  input  1  raw ADJ slide switch, asynchronous to clk.
REQ-007 sw_sel_raw  input  1  raw SEL slide switch (0=minutes, 1=seconds), asynchronous to clk.
REQ-008 btn_pause_raw  input  1  raw PAUSE push button, asynchronous to clk, active-high.
REQ-009 adj  output  1  debounced ADJ level; drives the mode FSM adj input.
REQ-010 sel  output  1  debounced SEL level; drives the mode FSM sel input.
REQ-011 pause_tog  output  1  one-cycle pulse per accepted PAUSE press; drives the mode FSM pause_tog input.

Function
REQ-012 Each raw input SHALL pass through a SYNC_STAGES-deep flop chain before any other logic.
REQ-013 Each channel SHALL hold a stable register and a CNT_W-bit counter: the counter clears whenever synced == stable, and increments by 1 each cycle while synced != stable.
REQ-014 When synced != stable and the counter equals DB_CYCLES-1, stable SHALL take synced on that edge and the counter SHALL clear.
REQ-015 Latency: a clean raw level change SHALL appear on adj/sel exactly SYNC_STAGES+DB_CYCLES cycles after the first clk edge that samples the new raw level.
REQ-016 Any synced level excursion shorter than DB_CYCLES cycles SHALL leave stable unchanged and SHALL reset the counter when synced returns to stable.
REQ-017 The counter SHALL never wrap; it is bounded by DB_CYCLES-1 by construction.
REQ-018 adj and sel SHALL be the stable registers of their channels, driven directly from flops (no combinational path from raw inputs).
REQ-019 pause_tog SHALL be registered and high for exactly one cycle, namely the first cycle in which the pause stable register reads 1 after reading 0, and only if the pause channel is armed.
REQ-020 Pause-channel armed flag: clear at reset; set on the first edge where the pause stable register is 0 and no pause commit is in progress (synced == stable == 0); once set it stays set until reset.
REQ-021 A PAUSE button held through reset release SHALL NOT produce pause_tog; the first pulse follows a release of at least DB_CYCLES cycles and then a new press.
REQ-022 Holding PAUSE SHALL produce exactly one pulse; release SHALL produce none.
REQ-023 Simultaneous commits on multiple channels in the same cycle SHALL all take effect on that edge, with no priority or serialisation between channels.

Reset
REQ-024 When rst is low: all synchroniser flops 0, all stable registers 0, all counters 0, armed 0, adj=0, sel=0, pause_tog=0, all applied asynchronously.
REQ-025 Reset asserted mid-debounce SHALL abandon the count, with no commit after release; a pause_tog pulse in flight SHALL be cleared immediately.
REQ-026 Reset release SHALL be the only event that restarts sampling; the first synchroniser capture occurs on the first clk edge with rst high.

Structure
REQ-027 SYNC_STAGES and DB_CYCLES defaults, and the clock-rate-derived debounce constant, SHALL live in the shared clock package alongside the 1 Hz/2 Hz divider constants.
REQ-028 One sub-module, debounce_chan (synchroniser + counter + stable register + rise-pulse output), SHALL be instantiated three times; the armed flag SHALL reside in input_conditioner.
REQ-029 The mode FSM SHALL consume adj, sel and pause_tog unmodified, with no further glue logic.

Verification (DB_CYCLES=4, SYNC_STAGES=2)
REQ-030 Reset, then sw_adj_raw 0->1 held -> adj rises exactly 6 cycles later and stays 1; pause_tog remains 0.
REQ-031 btn_pause_raw bounces 1,0,1,0 (1 cycle each), then held 1 for 10 cycles -> exactly one pause_tog pulse, 6 cycles after the final rising sample.
REQ-032 btn_pause_raw high 3 cycles only -> no pause_tog; pause stable register stays 0.
REQ-033 btn_pause_raw held 1 across reset release -> no pulse; then release for 6 cycles, press for 6 cycles -> exactly one pulse.
REQ-034 sw_sel_raw 0->1 at cycle 2 of a 4-cycle count, with rst pulsed low -> sel=0 immediately, no commit after release until a fresh 6-cycle hold.
REQ-035 sw_adj_raw and sw_sel_raw toggle on the same edge -> adj and sel change on the same cycle.
